// File: rtl/voice_scheduler.sv
// Polyphonic note scheduler: assigns validated note codes to C_VOICES timed voice slots,
// retriggering a matching slot, filling a free one, or stealing the oldest.
module voice_scheduler #(
    parameter int C_CLK_FRQ    = 100_000_000,
    parameter int C_NOTE_MS    = 500,
    parameter int C_VOICES     = 4,
    parameter int C_DATA_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rstb,
    input  logic                             note_valid,
    input  logic                             note_err,
    input  logic [C_DATA_WIDTH-1:0]          note_code,
    output logic                             note_ready,
    output logic [C_VOICES*C_DATA_WIDTH-1:0] voice_note,
    output logic [C_VOICES-1:0]              voice_active,
    output logic                             steal_pulse,
    output logic                             drop_pulse
);

    localparam longint C_PERIOD_L = (longint'(C_CLK_FRQ) * longint'(C_NOTE_MS)) / 1000;
    localparam int     C_PERIOD   = int'(C_PERIOD_L);
    localparam int     W          = C_DATA_WIDTH;
    localparam int     TW         = $clog2(C_PERIOD + 1);
    localparam int     AW         = $clog2(C_PERIOD + C_VOICES);
    localparam int     IW         = $clog2(C_VOICES);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        ASSIGN
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]        slot_note [C_VOICES];
    logic [TW-1:0]       slot_tmr  [C_VOICES];
    logic [C_VOICES-1:0] slot_act;

    logic [W-1:0]  code_q;
    logic [IW-1:0] scan_idx;
    logic          match_hit, free_hit, old_hit;
    logic [IW-1:0] match_idx, free_idx, old_idx;
    logic [AW-1:0] old_age;
    logic          steal_q;

    logic          accept, all_off, drop;
    logic          do_assign;
    logic [IW-1:0] tgt_idx;
    logic          tgt_steal;
    logic          cur_act;
    logic [W-1:0]  cur_note;
    logic [AW-1:0] cur_age;

    // note_ready is only ever high while the FSM sits in IDLE
    assign accept  = note_valid && !note_err && note_ready && (state == IDLE) && (note_code != '0);
    assign all_off = note_valid && !note_err && note_ready && (state == IDLE) && (note_code == '0);
    assign drop    = note_valid && (note_err || !note_ready);

    assign cur_act  = slot_act[scan_idx];
    assign cur_note = slot_note[scan_idx];
    assign cur_age  = AW'(slot_tmr[scan_idx]);

    always_comb begin
        state_nxt = state;
        do_assign = 1'b0;
        case (state)
            IDLE:    if (accept) state_nxt = SCAN;
            SCAN:    if (scan_idx == IW'(C_VOICES - 1)) state_nxt = ASSIGN;
            ASSIGN: begin
                do_assign = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tgt_idx   = old_idx;
        tgt_steal = 1'b1;
        if (match_hit) begin
            tgt_idx   = match_idx;
            tgt_steal = 1'b0;
        end else if (free_hit) begin
            tgt_idx   = free_idx;
            tgt_steal = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else       state <= state_nxt;
    end

    // old_age tracks the recorded slot's timer as it would read now, so every
    // comparison is between ages sampled in the same cycle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            code_q    <= '0;
            scan_idx  <= '0;
            match_hit <= 1'b0;
            free_hit  <= 1'b0;
            old_hit   <= 1'b0;
            match_idx <= '0;
            free_idx  <= '0;
            old_idx   <= '0;
            old_age   <= '0;
        end else if (accept) begin
            code_q    <= note_code;
            scan_idx  <= '0;
            match_hit <= 1'b0;
            free_hit  <= 1'b0;
            old_hit   <= 1'b0;
        end else if (state == SCAN) begin
            scan_idx <= scan_idx + 1'b1;
            if (cur_act && (cur_note == code_q) && !match_hit) begin
                match_hit <= 1'b1;
                match_idx <= scan_idx;
            end
            if (!cur_act && !free_hit) begin
                free_hit <= 1'b1;
                free_idx <= scan_idx;
            end
            if (cur_act && (!old_hit || (cur_age > old_age))) begin
                old_hit <= 1'b1;
                old_idx <= scan_idx;
                old_age <= cur_age + 1'b1;
            end else if (old_hit) begin
                old_age <= old_age + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            slot_act <= '0;
            for (int unsigned i = 0; i < C_VOICES; i++) begin
                slot_note[i] <= '0;
                slot_tmr[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < C_VOICES; i++) begin
                if (all_off) begin
                    slot_act[i]  <= 1'b0;
                    slot_note[i] <= '0;
                    slot_tmr[i]  <= '0;
                end else if (do_assign && (tgt_idx == IW'(i))) begin
                    slot_act[i]  <= 1'b1;
                    slot_note[i] <= code_q;
                    slot_tmr[i]  <= '0;
                end else if (slot_act[i]) begin
                    if (slot_tmr[i] == TW'(C_PERIOD - 1)) begin
                        slot_act[i]  <= 1'b0;
                        slot_note[i] <= '0;
                        slot_tmr[i]  <= '0;
                    end else begin
                        slot_tmr[i] <= slot_tmr[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Outputs mirror the slot registers one cycle later; all-off clears them directly.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            voice_note   <= '0;
            voice_active <= '0;
            note_ready   <= 1'b1;
            steal_q      <= 1'b0;
            steal_pulse  <= 1'b0;
            drop_pulse   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < C_VOICES; i++) begin
                voice_note[i*W +: W] <= all_off ? '0 : slot_note[i];
            end
            voice_active <= all_off ? '0 : slot_act;
            note_ready   <= (state == IDLE) && !accept;
            steal_q      <= do_assign && tgt_steal;
            steal_pulse  <= steal_q;
            drop_pulse   <= drop;
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Scoreboard bench for voice_scheduler: a start-time based reference model predicts every
// output change; a monitor compares each DUT output event against the predicted queue.
module tb_voice_scheduler;

    localparam int CLK_FRQ = 1000;
    // Period long enough that four voices can all be busy when a fifth note arrives.
    localparam int NOTE_MS = 40;
    localparam int V       = 4;
    localparam int W       = 8;
    localparam int P       = CLK_FRQ * NOTE_MS / 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rstb;
    logic           note_valid, note_err;
    logic [W-1:0]   note_code;
    logic           note_ready;
    logic [V*W-1:0] voice_note;
    logic [V-1:0]   voice_active;
    logic           steal_pulse, drop_pulse;

    voice_scheduler #(
        .C_CLK_FRQ   (CLK_FRQ),
        .C_NOTE_MS   (NOTE_MS),
        .C_VOICES    (V),
        .C_DATA_WIDTH(W)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .note_valid  (note_valid),
        .note_err    (note_err),
        .note_code   (note_code),
        .note_ready  (note_ready),
        .voice_note  (voice_note),
        .voice_active(voice_active),
        .steal_pulse (steal_pulse),
        .drop_pulse  (drop_pulse)
    );

    typedef struct packed {
        logic [V*W-1:0] notes;
        logic [V-1:0]   act;
        logic           rdy;
        logic           steal;
        logic           drop;
    } snap_t;

    typedef struct {
        int    cyc;
        snap_t s;
    } exp_t;

    exp_t expq[$];
    int   tests = 0;
    int   fails = 0;
    int   edge_n = 0;
    bit   mon_en = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Reference model: each slot remembers the edge its note became internally live.
    bit           m_val  [V];
    int           m_start[V];
    logic [W-1:0] m_note [V];
    bit           pend_v;
    int           pend_edge, pend_slot;
    logic [W-1:0] pend_code;
    bit           pend_steal;
    bit           steal_next;
    int           rdy_from;
    snap_t        last_exp;

    task automatic model_reset();
        for (int j = 0; j < V; j++) begin
            m_val[j] = 0; m_start[j] = 0; m_note[j] = '0;
        end
        pend_v = 0; steal_next = 0; rdy_from = -1000;
        last_exp = '0;
        last_exp.rdy = 1'b1;
        expq.delete();
    endtask

    function automatic bit live(input int j, input int e);
        return m_val[j] && (m_start[j] <= e) && (e <= m_start[j] + P - 1);
    endfunction

    task automatic model_edge(input int c, input logic v, input logic e, input logic [W-1:0] code);
        snap_t s;
        bit    rdy_prev;
        int    mt, fr, ol, ol_st;
        rdy_prev = ((c - 1) >= rdy_from);
        s = '0;
        for (int j = 0; j < V; j++) begin
            if (live(j, c - 1)) begin
                s.notes[j*W +: W] = m_note[j];
                s.act[j] = 1'b1;
            end
        end
        s.drop = v && (e || !rdy_prev);
        s.steal = steal_next;
        steal_next = 0;
        if (pend_v && pend_edge == c) begin
            m_val[pend_slot] = 1; m_start[pend_slot] = c; m_note[pend_slot] = pend_code;
            steal_next = pend_steal;
            pend_v = 0;
        end
        if (v && !e && rdy_prev && code == '0) begin
            s.notes = '0; s.act = '0;
            for (int j = 0; j < V; j++) m_val[j] = 0;
        end
        if (v && !e && rdy_prev && code != '0) begin
            mt = -1; fr = -1; ol = -1; ol_st = 0;
            for (int k = 0; k < V; k++) begin
                bit a;
                a = live(k, c + k);
                if (a && m_note[k] == code && mt < 0) mt = k;
                if (!a && fr < 0) fr = k;
                if (a && (ol < 0 || m_start[k] < ol_st)) begin
                    ol = k; ol_st = m_start[k];
                end
            end
            pend_v = 1; pend_edge = c + V + 1; pend_code = code;
            pend_slot = (mt >= 0) ? mt : (fr >= 0) ? fr : ol;
            pend_steal = (mt < 0) && (fr < 0);
            rdy_from = c + V + 2;
        end
        s.rdy = (c >= rdy_from);
        if (s != last_exp || s.steal || s.drop) expq.push_back('{c, s});
        last_exp = s;
    endtask

    task automatic cyc(input logic v, input logic e, input logic [W-1:0] code);
        @(negedge clk);
        #1;
        note_valid = v; note_err = e; note_code = code;
        model_edge(edge_n + 1, v, e, code);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, '0);
    endtask

    task automatic send(input logic [W-1:0] code, input int gap);
        cyc(1'b1, 1'b0, code);
        idle(gap - 1);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic monitor_loop();
        snap_t d, last_d;
        bit    was_en;
        exp_t  x;
        was_en = 0;
        last_d = '0;
        forever begin
            @(negedge clk);
            d.notes = voice_note; d.act = voice_active; d.rdy = note_ready;
            d.steal = steal_pulse; d.drop = drop_pulse;
            if (mon_en && was_en) begin
                while (expq.size() > 0 && expq[0].cyc < edge_n) begin
                    x = expq.pop_front();
                    tests++; fails++;
                    $display("FAIL missed_event: edge %0d required %h, outputs did not show it", x.cyc, x.s);
                end
                if (d != last_d || d.steal || d.drop || (expq.size() > 0 && expq[0].cyc == edge_n)) begin
                    tests++;
                    if (expq.size() == 0 || expq[0].cyc != edge_n) begin
                        fails++;
                        $display("FAIL unexpected_event: edge %0d got %h, required unchanged %h", edge_n, d, last_d);
                    end else begin
                        x = expq.pop_front();
                        if (d !== x.s) begin
                            fails++;
                            $display("FAIL output_event: edge %0d got %h, required %h", edge_n, d, x.s);
                        end
                    end
                end
            end
            last_d = d;
            was_en = mon_en;
        end
    endtask

    initial begin
        rstb = 1'b0; note_valid = 1'b0; note_err = 1'b0; note_code = '0;
        model_reset();
        fork
            monitor_loop();
        join_none
        repeat (3) @(posedge clk);
        #2;
        chk("reset_voice_note", 64'(voice_note), 64'd0);
        chk("reset_voice_active", 64'(voice_active), 64'd0);
        chk("reset_note_ready", 64'(note_ready), 64'd1);
        chk("reset_steal", 64'(steal_pulse), 64'd0);
        chk("reset_drop", 64'(drop_pulse), 64'd0);
        @(negedge clk);
        rstb = 1'b1;
        mon_en = 1;
        idle(2);

        send(8'h3C, 60);
        send(8'h3C, 7); send(8'h3E, 7); send(8'h40, 7); send(8'h41, 7);
        send(8'h43, 70);
        send(8'h3C, 15); send(8'h3C, 70);
        cyc(1'b1, 1'b1, 8'h3C); idle(3);
        cyc(1'b1, 1'b0, 8'h45); cyc(1'b0, 1'b0, '0); cyc(1'b1, 1'b0, 8'h47); idle(60);
        send(8'h3C, 7); send(8'h3E, 7); send(8'h40, 10);
        cyc(1'b1, 1'b0, 8'h00); idle(10);

        for (int n = 0; n < 2500; n++) begin
            logic [W-1:0] code;
            code = ($urandom_range(19, 0) == 0) ? 8'h00 : 8'(8'h3C + $urandom_range(5, 0));
            if ($urandom_range(3, 0) == 0)
                cyc(1'b1, ($urandom_range(7, 0) == 0), code);
            else
                idle(1);
        end
        idle(P + 10);
        chk("queue_drained_random", 64'(expq.size()), 64'd0);

        send(8'h41, 9);
        mon_en = 0;
        cyc(1'b1, 1'b0, 8'h3C);
        cyc(1'b0, 1'b0, '0);
        @(posedge clk);
        #2;
        chk("pre_reset_active", 64'(voice_active), 64'd1);
        chk("pre_reset_ready", 64'(note_ready), 64'd0);
        #1 rstb = 1'b0;
        #1;
        chk("async_reset_voice_note", 64'(voice_note), 64'd0);
        chk("async_reset_voice_active", 64'(voice_active), 64'd0);
        chk("async_reset_note_ready", 64'(note_ready), 64'd1);
        @(negedge clk);
        #2 rstb = 1'b1;
        model_reset();
        mon_en = 1;
        idle(1);
        send(8'h3C, 10);
        idle(P + 10);
        chk("queue_drained_final", 64'(expq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
